overdrive_step_ctrl: RTL and testbench

//  Head-positioning stage between the floppy bus and the read/write circuit. Qualifies bus

---
 rtl/overdrive_step_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_overdrive_step_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/overdrive_step_ctrl.sv
// overdrive_step_ctrl
//   Head-positioning stage between the floppy bus and the read/write circuit.
//   Synchronises the bus step/dir_sel/t00_sens lines, queues qualified step
//   commands in a small FIFO, and drives the stepper motor with a timed pulse
//   followed by a head-settle interval. Keeps the current track number.
//
//   Optional feature macro: OVERDRIVE_DOUBLE_STEP_EN
//     When defined, adds input double_step. A command popped with
//     double_step=1 issues two pulse+settle sequences in the same direction
//     but moves the logical track count by one, saturating at MAX_TRACK/2.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   drive_en       in   this drive selected
//   step           in   bus step request (async)
//   dir_sel        in   1 = inward (count up), 0 = outward (async)
//   t00_sens       in   track-00 optical sensor (async)
//   double_step    in   (feature build only) two physical steps per command
//   step_motor     out  stepper pulse to motor driver
//   step_dir       out  direction to motor driver
//   track_0        out  registered (int_trk_count == 0)
//   int_trk_count  out  current track number
//   seek_busy      out  FSM not idle or commands queued
//   step_ovf       out  sticky: a step was dropped on a full FIFO
module overdrive_step_ctrl #(
  parameter int MAX_TRACK       = 79,
  parameter int FIFO_DEPTH      = 8,
  parameter int MOTOR_PULSE_CYC = 1000,
  parameter int SETTLE_CYC      = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drive_en,
  input  logic       step,
  input  logic       dir_sel,
  input  logic       t00_sens,
`ifdef OVERDRIVE_DOUBLE_STEP_EN
  input  logic       double_step,
`endif
  output logic       step_motor,
  output logic       step_dir,
  output logic       track_0,
  output logic [6:0] int_trk_count,
  output logic       seek_busy,
  output logic       step_ovf
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int TIMER_MAX = (MOTOR_PULSE_CYC > SETTLE_CYC) ? MOTOR_PULSE_CYC : SETTLE_CYC;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  localparam logic [TIMER_W-1:0] PULSE_LAST  = TIMER_W'(MOTOR_PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [6:0]         TRACK_MAX   = 7'(MAX_TRACK);
  localparam logic [CNT_W-1:0]   FIFO_FULL   = CNT_W'(FIFO_DEPTH);
`ifdef OVERDRIVE_DOUBLE_STEP_EN
  localparam logic [6:0]         TRACK_MAX_HALF = 7'(MAX_TRACK / 2);
`endif

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE} state_t;

  logic step_meta, step_sync, step_sync_d;
  logic dir_meta, dir_sync;
  logic t00_meta, t00_sync;
  logic push_req, push_dir;

  logic [FIFO_DEPTH-1:0] fifo_mem;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_cnt;
  logic                  fifo_empty, fifo_full, push_ok, pop, pop_dir;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 motor_nxt, dir_nxt;
  logic [6:0]           count_nxt, limit;
  logic                 second_pending, second_nxt, dbl;

  // Input synchronisers. The edge detect is registered together with the
  // synced direction so a command reaches the FIFO one clock after the edge
  // is seen; this gives the fixed sample-to-pulse latency of four clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_meta   <= 1'b0;
      step_sync   <= 1'b0;
      step_sync_d <= 1'b0;
      dir_meta    <= 1'b0;
      dir_sync    <= 1'b0;
      t00_meta    <= 1'b0;
      t00_sync    <= 1'b0;
      push_req    <= 1'b0;
      push_dir    <= 1'b0;
    end else begin
      step_meta   <= step;
      step_sync   <= step_meta;
      step_sync_d <= step_sync;
      dir_meta    <= dir_sel;
      dir_sync    <= dir_meta;
      t00_meta    <= t00_sens;
      t00_sync    <= t00_meta;
      push_req    <= step_sync & ~step_sync_d & drive_en;
      push_dir    <= dir_sync;
    end
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  // A simultaneous pop frees a slot, so a push on a full FIFO still lands.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign pop_dir    = fifo_mem[rd_ptr];
  assign seek_busy  = (state != IDLE) | ~fifo_empty;

  // Direction FIFO and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      step_ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= push_dir;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_req && !push_ok) begin
        step_ovf <= 1'b1;
      end
    end
  end

  // Next-state logic. A sensor resync in IDLE takes the cycle by itself; the
  // queued command is popped on the following cycle.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    motor_nxt  = step_motor;
    dir_nxt    = step_dir;
    count_nxt  = int_trk_count;
    second_nxt = second_pending;
    pop        = 1'b0;
    dbl        = 1'b0;
    limit      = TRACK_MAX;
`ifdef OVERDRIVE_DOUBLE_STEP_EN
    dbl = double_step;
    if (double_step) begin
      limit = TRACK_MAX_HALF;
    end
`endif
    case (state)
      IDLE: begin
        timer_nxt = '0;
        if (t00_sync && (int_trk_count != '0)) begin
          count_nxt = '0;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          // Inward at the limit is swallowed without moving the head.
          if (!(pop_dir && (int_trk_count >= limit))) begin
            dir_nxt    = pop_dir;
            motor_nxt  = 1'b1;
            state_nxt  = PULSE;
            second_nxt = dbl;
            if (pop_dir) begin
              count_nxt = int_trk_count + 7'd1;
            end else if (int_trk_count != '0) begin
              count_nxt = int_trk_count - 7'd1;
            end
          end
        end
      end
      PULSE: begin
        if (timer == PULSE_LAST) begin
          timer_nxt = '0;
          motor_nxt = 1'b0;
          state_nxt = SETTLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      SETTLE: begin
        if (timer == SETTLE_LAST) begin
          timer_nxt = '0;
          if (second_pending) begin
            second_nxt = 1'b0;
            motor_nxt  = 1'b1;
            state_nxt  = PULSE;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        motor_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; track_0 follows the next count so it always
  // agrees with int_trk_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      timer          <= '0;
      step_motor     <= 1'b0;
      step_dir       <= 1'b0;
      int_trk_count  <= '0;
      track_0        <= 1'b1;
      second_pending <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      step_motor     <= motor_nxt;
      step_dir       <= dir_nxt;
      int_trk_count  <= count_nxt;
      track_0        <= (count_nxt == '0);
      second_pending <= second_nxt;
    end
  end

endmodule

// File: tb/tb_overdrive_step_ctrl.sv
// tb_overdrive_step_ctrl
//   Directed self-checking bench for overdrive_step_ctrl with a short pulse
//   and settle time. Define OVERDRIVE_DOUBLE_STEP_EN to cover double_step.
module tb_overdrive_step_ctrl;

  localparam int MAX_TRACK       = 79;
  localparam int FIFO_DEPTH      = 4;
  localparam int MOTOR_PULSE_CYC = 4;
  localparam int SETTLE_CYC      = 10;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       drive_en = 1'b1;
  logic       step     = 1'b0;
  logic       dir_sel  = 1'b0;
  logic       t00_sens = 1'b0;
`ifdef OVERDRIVE_DOUBLE_STEP_EN
  logic       double_step = 1'b0;
`endif
  logic       step_motor;
  logic       step_dir;
  logic       track_0;
  logic [6:0] int_trk_count;
  logic       seek_busy;
  logic       step_ovf;

  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  logic motor_prev = 1'b0;
  logic last_pulse_dir = 1'b0;

  overdrive_step_ctrl #(
    .MAX_TRACK      (MAX_TRACK),
    .FIFO_DEPTH     (FIFO_DEPTH),
    .MOTOR_PULSE_CYC(MOTOR_PULSE_CYC),
    .SETTLE_CYC     (SETTLE_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .drive_en     (drive_en),
    .step         (step),
    .dir_sel      (dir_sel),
    .t00_sens     (t00_sens),
`ifdef OVERDRIVE_DOUBLE_STEP_EN
    .double_step  (double_step),
`endif
    .step_motor   (step_motor),
    .step_dir     (step_dir),
    .track_0      (track_0),
    .int_trk_count(int_trk_count),
    .seek_busy    (seek_busy),
    .step_ovf     (step_ovf)
  );

  always #5 clk = ~clk;

  // Count motor pulses (rising edges) away from the active clock edge.
  always @(negedge clk) begin
    if (step_motor && !motor_prev) begin
      pulses++;
      last_pulse_dir = step_dir;
    end
    motor_prev = step_motor;
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // One-clock step pulse, sampled by exactly one rising clock edge.
  task automatic send_step(input logic dir);
    @(negedge clk);
    dir_sel = dir;
    step    = 1'b1;
    @(negedge clk);
    step    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (seek_busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (seek_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: seek_busy=%0b after %0d cycles, expected 0", name, seek_busy, budget);
    end
  endtask

  task automatic step_and_wait(input logic dir);
    send_step(dir);
    repeat (4) @(posedge clk);
    #1;
    wait_idle(100, "idle_after_step");
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (step_motor !== 1'b0) begin errors++; $display("[TB] FAIL rst_motor: got %0b expected 0", step_motor); end
    checks++; if (step_dir !== 1'b0) begin errors++; $display("[TB] FAIL rst_dir: got %0b expected 0", step_dir); end
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL rst_count: got %0d expected 0", int_trk_count); end
    checks++; if (track_0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_track0: got %0b expected 1", track_0); end
    checks++; if (seek_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b expected 0", seek_busy); end
    checks++; if (step_ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf: got %0b expected 0", step_ovf); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_single_step();
    send_step(1'b1);            // sampled at edge N, returns at N+0.5
    repeat (3) @(posedge clk);  // N+1..N+3
    #1;
    checks++; if (step_motor !== 1'b0) begin errors++; $display("[TB] FAIL lat_motor_early: got %0b expected 0", step_motor); end
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL lat_count_early: got %0d expected 0", int_trk_count); end
    @(posedge clk); #1;         // N+4
    checks++; if (step_motor !== 1'b1) begin errors++; $display("[TB] FAIL lat_motor_rise: got %0b expected 1", step_motor); end
    checks++; if (int_trk_count !== 7'd1) begin errors++; $display("[TB] FAIL lat_count: got %0d expected 1", int_trk_count); end
    checks++; if (track_0 !== 1'b0) begin errors++; $display("[TB] FAIL lat_track0: got %0b expected 0", track_0); end
    checks++; if (step_dir !== 1'b1) begin errors++; $display("[TB] FAIL lat_dir: got %0b expected 1", step_dir); end
    repeat (3) @(posedge clk); #1;  // N+7
    checks++; if (step_motor !== 1'b1) begin errors++; $display("[TB] FAIL pulse_last: got %0b expected 1", step_motor); end
    @(posedge clk); #1;             // N+8
    checks++; if (step_motor !== 1'b0) begin errors++; $display("[TB] FAIL pulse_end: got %0b expected 0", step_motor); end
    repeat (9) @(posedge clk); #1;  // N+17
    checks++; if (seek_busy !== 1'b1) begin errors++; $display("[TB] FAIL settle_busy: got %0b expected 1", seek_busy); end
    @(posedge clk); #1;             // N+18
    checks++; if (seek_busy !== 1'b0) begin errors++; $display("[TB] FAIL settle_done: got %0b expected 0", seek_busy); end
    checks++; if (step_ovf !== 1'b0) begin errors++; $display("[TB] FAIL single_ovf: got %0b expected 0", step_ovf); end
  endtask

  task automatic test_burst_overflow();
    int p0;
    do_reset();
    p0 = pulses;
    for (int i = 0; i < 6; i++) send_step(1'b1);
    wait_idle(300, "burst_idle");
    repeat (3) @(posedge clk); #1;
    checks++; if (int_trk_count !== 7'd5) begin errors++; $display("[TB] FAIL burst_count: got %0d expected 5", int_trk_count); end
    checks++; if (pulses - p0 != 5) begin errors++; $display("[TB] FAIL burst_pulses: got %0d expected 5", pulses - p0); end
    checks++; if (step_ovf !== 1'b1) begin errors++; $display("[TB] FAIL burst_ovf: got %0b expected 1", step_ovf); end
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    p0 = pulses;
    send_step(1'b1);
    send_step(1'b1);
    send_step(1'b0);
    wait_idle(200, "b2b_idle");
    checks++; if (int_trk_count !== 7'd1) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 1", int_trk_count); end
    checks++; if (pulses - p0 != 3) begin errors++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", pulses - p0); end
    checks++; if (last_pulse_dir !== 1'b0) begin errors++; $display("[TB] FAIL b2b_last_dir: got %0b expected 0", last_pulse_dir); end
    checks++; if (step_ovf !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ovf: got %0b expected 0", step_ovf); end
  endtask

  task automatic test_saturate_max();
    int p0;
    do_reset();
    for (int i = 0; i < 78; i++) step_and_wait(1'b1);
    checks++; if (int_trk_count !== 7'd78) begin errors++; $display("[TB] FAIL sat_reach78: got %0d expected 78", int_trk_count); end
    p0 = pulses;
    step_and_wait(1'b1);
    checks++; if (int_trk_count !== 7'd79) begin errors++; $display("[TB] FAIL sat_reach79: got %0d expected 79", int_trk_count); end
    checks++; if (pulses - p0 != 1) begin errors++; $display("[TB] FAIL sat_last_pulse: got %0d expected 1", pulses - p0); end
    p0 = pulses;
    for (int i = 0; i < 79; i++) step_and_wait(1'b1);
    checks++; if (int_trk_count !== 7'd79) begin errors++; $display("[TB] FAIL sat_hold: got %0d expected 79", int_trk_count); end
    checks++; if (pulses - p0 != 0) begin errors++; $display("[TB] FAIL sat_no_pulse: got %0d expected 0", pulses - p0); end
    checks++; if (track_0 !== 1'b0) begin errors++; $display("[TB] FAIL sat_track0: got %0b expected 0", track_0); end
  endtask

  task automatic test_outward_at_zero();
    int p0;
    do_reset();
    step_and_wait(1'b1);
    step_and_wait(1'b0);
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL out_back_to0: got %0d expected 0", int_trk_count); end
    p0 = pulses;
    step_and_wait(1'b0);
    checks++; if (pulses - p0 != 1) begin errors++; $display("[TB] FAIL out0_pulse: got %0d expected 1", pulses - p0); end
    checks++; if (last_pulse_dir !== 1'b0) begin errors++; $display("[TB] FAIL out0_dir: got %0b expected 0", last_pulse_dir); end
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL out0_count: got %0d expected 0", int_trk_count); end
    checks++; if (track_0 !== 1'b1) begin errors++; $display("[TB] FAIL out0_track0: got %0b expected 1", track_0); end
  endtask

  task automatic test_resync_and_drive_en();
    int p0;
    do_reset();
    for (int i = 0; i < 12; i++) step_and_wait(1'b1);
    checks++; if (int_trk_count !== 7'd12) begin errors++; $display("[TB] FAIL resync_pre: got %0d expected 12", int_trk_count); end
    @(negedge clk);
    t00_sens = 1'b1;               // sampled at edge M
    repeat (2) @(posedge clk); #1; // M+1
    checks++; if (int_trk_count !== 7'd12) begin errors++; $display("[TB] FAIL resync_early: got %0d expected 12", int_trk_count); end
    repeat (2) @(posedge clk); #1; // M+3
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL resync_count: got %0d expected 0", int_trk_count); end
    checks++; if (track_0 !== 1'b1) begin errors++; $display("[TB] FAIL resync_track0: got %0b expected 1", track_0); end
    @(negedge clk);
    t00_sens = 1'b0;
    p0 = pulses;
    drive_en = 1'b0;
    send_step(1'b1);
    repeat (20) @(posedge clk); #1;
    checks++; if (pulses - p0 != 0) begin errors++; $display("[TB] FAIL desel_pulses: got %0d expected 0", pulses - p0); end
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL desel_count: got %0d expected 0", int_trk_count); end
    checks++; if (seek_busy !== 1'b0) begin errors++; $display("[TB] FAIL desel_busy: got %0b expected 0", seek_busy); end
    drive_en = 1'b1;
  endtask

  task automatic test_reset_mid_pulse();
    int p0;
    do_reset();
    send_step(1'b1);
    send_step(1'b1);
    send_step(1'b1);               // first sampled at N, returns at N+4.5
    repeat (3) @(posedge clk); #1; // N+7, mid pulse
    checks++; if (step_motor !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_motor: got %0b expected 1", step_motor); end
    rst = 1'b0;
    #1;
    checks++; if (step_motor !== 1'b0) begin errors++; $display("[TB] FAIL midrst_motor: got %0b expected 0", step_motor); end
    checks++; if (seek_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", seek_busy); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    p0 = pulses;
    repeat (25) @(posedge clk); #1;
    checks++; if (int_trk_count !== 7'd0) begin errors++; $display("[TB] FAIL midrst_count: got %0d expected 0", int_trk_count); end
    checks++; if (pulses - p0 != 0) begin errors++; $display("[TB] FAIL midrst_fifo_empty: got %0d pulses expected 0", pulses - p0); end
    checks++; if (seek_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got %0b expected 0", seek_busy); end
  endtask

`ifdef OVERDRIVE_DOUBLE_STEP_EN
  task automatic test_double_step();
    int p0;
    do_reset();
    p0 = pulses;
    double_step = 1'b1;
    send_step(1'b1);
    repeat (4) @(posedge clk); #1;
    wait_idle(200, "dbl_idle");
    double_step = 1'b0;
    checks++; if (pulses - p0 != 2) begin errors++; $display("[TB] FAIL dbl_pulses: got %0d expected 2", pulses - p0); end
    checks++; if (int_trk_count !== 7'd1) begin errors++; $display("[TB] FAIL dbl_count: got %0d expected 1", int_trk_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_step();
    test_burst_overflow();
    test_back_to_back();
    test_saturate_max();
    test_outward_at_zero();
    test_resync_and_drive_en();
    test_reset_mid_pulse();
`ifdef OVERDRIVE_DOUBLE_STEP_EN
    test_double_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
